// File: rtl/iscbdiv_sched.sv
// Round-robin scheduler that time-shares one in-stream correlation divider among
// NREQ requesters: flush, warm-up, count quotient ones over a window, report.
module iscbdiv_sched #(
  parameter int NREQ   = 4,
  parameter int LEN_W  = 8,
  parameter int WARMUP = 2   // synchronizer depth; must be >= 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          sel_in,
  input  logic [NREQ*LEN_W-1:0]    len_in,
  input  logic [NREQ-1:0]          dividend_in,
  input  logic [NREQ-1:0]          divisor_in,
  output logic [NREQ-1:0]          grant,
  output logic                     stream_en,
  output logic                     div_rst_n,
  output logic                     div_sel,
  output logic                     div_dividend,
  output logic                     div_divisor,
  input  logic                     div_quotient,
  output logic                     done,
  output logic [$clog2(NREQ)-1:0]  done_id,
  output logic [LEN_W-1:0]         result
);

  localparam int IDX_W  = $clog2(NREQ);
  localparam int WARM_W = $clog2(WARMUP + 1);
  localparam int CNT_W  = (LEN_W > WARM_W) ? LEN_W : WARM_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_WARM,
    S_RUN,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic [IDX_W-1:0]  rr_q, rr_d;
  logic              sel_q, sel_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LEN_W-1:0]  acc_q, acc_d;
  logic [IDX_W-1:0]  done_id_q, done_id_d;
  logic [LEN_W-1:0]  result_q, result_d;

  logic              arb_hit;
  logic [IDX_W-1:0]  arb_idx;
  logic [IDX_W-1:0]  cand;
  logic [LEN_W-1:0]  len_pick;

  function automatic logic [IDX_W-1:0] inc_wrap(input logic [IDX_W-1:0] v);
    return (v == IDX_W'(NREQ - 1)) ? '0 : v + IDX_W'(1);
  endfunction

  // Round-robin search: walk from the pointer, first asserted request wins.
  // NOTE: every variable written in a combinational block gets a default first,
  // otherwise a path that skips the assignment infers a latch.
  always_comb begin
    arb_hit  = 1'b0;
    arb_idx  = '0;
    cand     = rr_q;
    len_pick = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!arb_hit && req[cand]) begin
        arb_hit = 1'b1;
        arb_idx = cand;
      end
      cand = inc_wrap(cand);
    end
    for (int i = 0; i < NREQ; i++) begin
      if (arb_idx == IDX_W'(i)) len_pick = len_in[i*LEN_W +: LEN_W];
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    owner_d   = owner_q;
    rr_d      = rr_q;
    sel_d     = sel_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    done_id_d = done_id_q;
    result_d  = result_q;

    unique case (state_q)
      S_IDLE: ;
      S_FLUSH: begin
        state_d = S_WARM;
        cnt_d   = '0;
        acc_d   = '0;
      end
      S_WARM: begin
        if (cnt_q == CNT_W'(WARMUP - 1)) begin
          cnt_d = '0;
          if (len_q == '0) begin
            state_d   = S_DONE;
            result_d  = '0;
            done_id_d = owner_q;
          end else begin
            state_d = S_RUN;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RUN: begin
        acc_d = acc_q + LEN_W'(div_quotient);
        if (cnt_q == CNT_W'(len_q) - CNT_W'(1)) begin
          state_d   = S_DONE;
          result_d  = acc_q + LEN_W'(div_quotient);
          done_id_d = owner_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
      default: state_d = S_IDLE;
    endcase

    // Requests are only looked at between jobs; DONE chains straight into FLUSH.
    if (arb_hit && (state_q == S_IDLE || state_q == S_DONE)) begin
      state_d = S_FLUSH;
      grant_d = {{(NREQ-1){1'b0}}, 1'b1} << arb_idx;
      owner_d = arb_idx;
      rr_d    = inc_wrap(arb_idx);
      sel_d   = sel_in[arb_idx];
      len_d   = len_pick;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      grant_q   <= '0;
      owner_q   <= '0;
      rr_q      <= '0;
      sel_q     <= 1'b0;
      len_q     <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      done_id_q <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      owner_q   <= owner_d;
      rr_q      <= rr_d;
      sel_q     <= sel_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      done_id_q <= done_id_d;
      result_q  <= result_d;
    end
  end

  // Divider inputs are forced low outside WARM/RUN so the flush sees clean zeros.
  assign grant        = grant_q;
  assign stream_en    = (state_q == S_WARM) || (state_q == S_RUN);
  assign div_rst_n    = !rst && (state_q != S_FLUSH);
  assign div_sel      = sel_q;
  assign div_dividend = stream_en & |(dividend_in & grant_q);
  assign div_divisor  = stream_en & |(divisor_in & grant_q);
  assign done         = (state_q == S_DONE);
  assign done_id      = done_id_q;
  assign result       = result_q;

endmodule

// File: tb/tb_iscbdiv_sched.sv
// Bench for iscbdiv_sched: directed job scenarios plus random traffic, all
// compared cycle by cycle against a job-phase reference model.
module tb_iscbdiv_sched;

  localparam int NREQ  = 4;
  localparam int LEN_W = 8;
  localparam int W     = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req, sel_in, dividend_in, divisor_in;
  logic [NREQ*LEN_W-1:0] len_in;
  logic [NREQ-1:0]       grant;
  logic                  stream_en, div_rst_n, div_sel, div_dividend, div_divisor;
  logic                  div_quotient;
  logic                  done;
  logic [1:0]            done_id;
  logic [LEN_W-1:0]      result;

  iscbdiv_sched #(.NREQ(NREQ), .LEN_W(LEN_W), .WARMUP(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .sel_in       (sel_in),
    .len_in       (len_in),
    .dividend_in  (dividend_in),
    .divisor_in   (divisor_in),
    .grant        (grant),
    .stream_en    (stream_en),
    .div_rst_n    (div_rst_n),
    .div_sel      (div_sel),
    .div_dividend (div_dividend),
    .div_divisor  (div_divisor),
    .div_quotient (div_quotient),
    .done         (done),
    .done_id      (done_id),
    .result       (result)
  );

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  // Stimulus controls
  logic             d_rst;
  logic [NREQ-1:0]  d_req, d_dvd, d_dvs;
  logic [LEN_W-1:0] d_len [NREQ];
  int               q_mode;        // 0: quotient 0, 1: quotient 1, 2: random
  bit               rand_streams;

  // Reference model: a job is described by its offset from the FLUSH cycle
  bit m_busy;
  int m_p, m_len, m_owner, m_rr, m_count, m_result, m_done_id;
  bit m_sel;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_cycle();
    int done_p;
    bit e_sen, e_done;
    @(negedge clk);
    rst = d_rst;
    req = d_req;
    for (int i = 0; i < NREQ; i++) len_in[i*LEN_W +: LEN_W] = d_len[i];
    if (rand_streams) begin
      dividend_in = 4'($urandom);
      divisor_in  = 4'($urandom);
      sel_in      = 4'($urandom);
    end else begin
      dividend_in = d_dvd;
      divisor_in  = d_dvs;
      sel_in      = '0;
    end
    div_quotient = (q_mode == 2) ? 1'($urandom_range(0, 1)) : (q_mode == 1);
    #1;
    done_p = W + m_len + 1;
    e_sen  = m_busy && m_p >= 1 && m_p <= W + m_len;
    e_done = m_busy && m_p == done_p;
    chk("grant",     grant,        m_busy ? (32'd1 << m_owner) : 32'd0);
    chk("stream_en", stream_en,    e_sen);
    chk("div_rst_n", div_rst_n,    !d_rst && !(m_busy && m_p == 0));
    chk("div_sel",   div_sel,      m_sel);
    chk("dividend",  div_dividend, e_sen && dividend_in[m_owner]);
    chk("divisor",   div_divisor,  e_sen && divisor_in[m_owner]);
    chk("done",      done,         e_done);
    chk("done_id",   done_id,      m_done_id);
    chk("result",    result,       m_result);

    // Model advance for the coming clock edge
    if (d_rst) begin
      m_busy = 0; m_rr = 0; m_sel = 0; m_result = 0; m_done_id = 0; m_len = 0;
    end else if (!m_busy || m_p == done_p) begin
      m_busy = 0;
      for (int k = 0; k < NREQ; k++) begin
        if (!m_busy && req[(m_rr + k) % NREQ]) begin
          m_busy  = 1;
          m_owner = (m_rr + k) % NREQ;
        end
      end
      if (m_busy) begin
        m_rr    = (m_owner + 1) % NREQ;
        m_len   = d_len[m_owner];
        m_sel   = sel_in[m_owner];
        m_p     = 0;
        m_count = 0;
      end
    end else begin
      if (m_p >= W + 1 && m_p <= W + m_len) m_count += div_quotient;
      m_p++;
      if (m_p == W + m_len + 1) begin
        m_result  = m_count;
        m_done_id = m_owner;
      end
    end
  endtask

  task automatic idle(input int n);
    d_req = '0;
    for (int i = 0; i < n; i++) do_cycle();
  endtask

  initial begin
    rst = 1'b1; req = '0; sel_in = '0; len_in = '0;
    dividend_in = '0; divisor_in = '0; div_quotient = 1'b0;
    d_rst = 1'b1; d_req = '0; d_dvd = '0; d_dvs = '0;
    for (int i = 0; i < NREQ; i++) d_len[i] = '0;
    q_mode = 2; rand_streams = 1;
    m_busy = 0; m_p = 0; m_len = 0; m_owner = 0; m_rr = 0;
    m_count = 0; m_result = 0; m_done_id = 0; m_sel = 0;

    // Reset
    for (int i = 0; i < 3; i++) do_cycle();
    d_rst = 1'b0;
    do_cycle();
    chk("reset_grant", grant, 0);
    chk("reset_result", result, 0);

    // Single job on requester 1, all-ones streams
    rand_streams = 0; d_dvd = '1; d_dvs = '1; q_mode = 1; d_len[1] = 8'd16;
    d_req = 4'b0010;
    do_cycle();
    d_req = '0;
    for (int c = 1; c <= 20; c++) begin
      do_cycle();
      if (c == 1) chk("single_grant", grant, 4'b0010);
      if (c == 1) chk("single_flush", div_rst_n, 0);
    end
    chk("single_done", done, 1);
    chk("single_id", done_id, 1);
    chk("single_result", result, 16);
    idle(2);

    // Zero dividend on requester 0
    d_dvd = '0; d_dvs = '1; q_mode = 0; d_len[0] = 8'd16;
    d_req = 4'b0001;
    do_cycle();
    d_req = '0;
    for (int c = 1; c <= 20; c++) do_cycle();
    chk("zero_done", done, 1);
    chk("zero_result", result, 0);
    idle(2);

    // Fairness from a fresh pointer: back-to-back jobs, 8 cycles each
    d_rst = 1'b1; do_cycle(); d_rst = 1'b0;
    rand_streams = 1; q_mode = 2;
    for (int i = 0; i < NREQ; i++) d_len[i] = 8'd4;
    d_req = 4'b1111;
    do_cycle();
    for (int c = 1; c <= 41; c++) begin
      do_cycle();
      if (c % 8 == 1) chk("fair_grant", grant, 32'd1 << (((c - 1) / 8) % NREQ));
    end
    idle(12);

    // len = 0 on requester 2
    d_len[2] = 8'd0;
    d_req = 4'b0100;
    do_cycle();
    d_req = '0;
    for (int c = 1; c <= 4; c++) do_cycle();
    chk("len0_done", done, 1);
    chk("len0_result", result, 0);
    idle(2);

    // Requester 3 drops req mid-RUN; job still completes
    d_len[3] = 8'd10;
    d_req = 4'b1000;
    for (int c = 0; c <= 5; c++) do_cycle();
    d_req = '0;
    for (int c = 6; c <= 14; c++) do_cycle();
    chk("drop_done", done, 1);
    chk("drop_id", done_id, 3);
    idle(2);

    // Reset during RUN aborts; afterwards the lowest asserted request wins
    d_len[3] = 8'd20;
    d_req = 4'b1000;
    do_cycle();
    d_req = '0;
    for (int c = 1; c <= 6; c++) do_cycle();
    d_rst = 1'b1;
    do_cycle();
    chk("abort_rstn", div_rst_n, 0);
    d_rst = 1'b0; d_req = 4'b1100;
    do_cycle();
    chk("abort_grant", grant, 0);
    chk("abort_done", done, 0);
    d_req = '0;
    do_cycle();
    chk("post_rst_grant", grant, 4'b0100);
    idle(8);

    // Maximum window, all-ones streams
    rand_streams = 0; d_dvd = '1; d_dvs = '1; q_mode = 1; d_len[0] = 8'd255;
    d_req = 4'b0001;
    do_cycle();
    d_req = '0;
    for (int c = 1; c <= 259; c++) do_cycle();
    chk("max_done", done, 1);
    chk("max_result", result, 255);
    idle(2);

    // Random traffic with occasional resets
    rand_streams = 1; q_mode = 2;
    for (int n = 0; n < 600; n++) begin
      d_req = 4'($urandom) & 4'($urandom);
      d_len[$urandom_range(0, NREQ - 1)] = 8'($urandom_range(0, 12));
      d_rst = ($urandom_range(0, 199) == 0);
      do_cycle();
    end
    d_rst = 1'b0;
    idle(20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
